// File: rtl/proxy_pe.sv
// -----------------------------------------------------------------------------
// proxy_pe
//   Spare processing element for one systolic column. On a load command it
//   latches the stationary weight of the faulty PE. On a matmul command it
//   recomputes that PE's MAC (top + left*weight). The result and valid flag
//   replace the faulty PE's bottom_out at the column output mux.
//
//   Data path: issue -> stage 1 (product, top) -> stage 2 (sum) -> output
//   register (formatted result). A beat issued at edge N appears on
//   proxy_result / proxy_result_valid after edge N+2.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load_proxy          weight-load command
//   proxy_matmul        compute command
//   proxy_settings      {stat_bit, out_select, op2_select}: 001 load, 110 matmul
//   rcm_weight          weight from the faulty-PE weight mux
//   proxy_left_in       activation (already retimed)
//   proxy_top_in        partial sum entering the faulty PE
//   proxy_in_valid      left/top valid this cycle
//   proxy_result        recomputed bottom_out (holds when not valid)
//   proxy_result_valid  proxy_result valid
//   weight_loaded       a stationary weight has been captured
//   proxy_state         0 IDLE, 1 LOADED, 2 COMPUTE
//   cmd_error           sticky illegal-command flag
// -----------------------------------------------------------------------------
module proxy_pe #(
    parameter int WORD_SIZE = 16,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_proxy,
    input  logic                 proxy_matmul,
    input  logic [2:0]           proxy_settings,
    input  logic [WORD_SIZE-1:0] rcm_weight,
    input  logic [WORD_SIZE-1:0] proxy_left_in,
    input  logic [WORD_SIZE-1:0] proxy_top_in,
    input  logic                 proxy_in_valid,
    output logic [WORD_SIZE-1:0] proxy_result,
    output logic                 proxy_result_valid,
    output logic                 weight_loaded,
    output logic [1:0]           proxy_state,
    output logic                 cmd_error
);

    localparam int W  = WORD_SIZE;
    localparam int PW = 2 * WORD_SIZE;

    localparam logic [2:0] SET_LOAD   = 3'b001;
    localparam logic [2:0] SET_MATMUL = 3'b110;

    // Clamp bounds expressed at full sum width.
    localparam logic signed [PW-1:0] SUM_MAX = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [PW-1:0] SUM_MIN = {{(W + 1){1'b1}}, {(W - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADED  = 2'd1,
        ST_COMPUTE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic cmd_load_s;
    logic cmd_matmul_s;
    logic cmd_illegal_s;
    logic weight_capture_s;
    logic issue_s;
    logic error_set_s;

    logic [W-1:0]          weight_r;
    logic                  s1_valid_r;
    logic signed [PW-1:0]  s1_prod_r;
    logic [W-1:0]          s1_top_r;
    logic                  s2_valid_r;
    logic signed [PW-1:0]  s2_sum_r;
    logic signed [PW-1:0]  mul_a_s;
    logic signed [PW-1:0]  mul_b_s;
    logic signed [PW-1:0]  prod_s;
    logic signed [PW-1:0]  sum_s;

    // Wrap or clamp the full-width sum into a WORD_SIZE result.
    function automatic logic [W-1:0] format_sum(input logic signed [PW-1:0] s);
        logic [W-1:0] r;
        if (SATURATE && (s > SUM_MAX)) begin
            r = {1'b0, {(W - 1){1'b1}}};
        end else if (SATURATE && (s < SUM_MIN)) begin
            r = {1'b1, {(W - 1){1'b0}}};
        end else begin
            r = s[W-1:0];
        end
        return r;
    endfunction

    // A set of settings bits is only meaningful for the matching strobe;
    // any strobe with an unknown setting is an illegal command.
    assign cmd_load_s    = load_proxy && (proxy_settings == SET_LOAD);
    assign cmd_matmul_s  = proxy_matmul && (proxy_settings == SET_MATMUL);
    assign cmd_illegal_s = (load_proxy || proxy_matmul) &&
                           (proxy_settings != SET_LOAD) &&
                           (proxy_settings != SET_MATMUL);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; LOAD takes priority, illegal commands hold state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_load_s) begin
                    state_next_s = ST_LOADED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOADED: begin
                if (cmd_matmul_s) begin
                    state_next_s = ST_COMPUTE;
                end else begin
                    state_next_s = ST_LOADED;
                end
            end
            ST_COMPUTE: begin
                if (cmd_load_s) begin
                    state_next_s = ST_LOADED;
                end else if (!proxy_matmul && !cmd_illegal_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_COMPUTE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Per-state control strobes: weight capture, beat issue, error set.
    always_comb begin
        weight_capture_s = 1'b0;
        issue_s          = 1'b0;
        error_set_s      = cmd_illegal_s;
        case (state_r)
            ST_IDLE: begin
                weight_capture_s = cmd_load_s;
                if (cmd_matmul_s) begin
                    error_set_s = 1'b1;
                end else begin
                    error_set_s = cmd_illegal_s;
                end
            end
            ST_LOADED: begin
                weight_capture_s = cmd_load_s;
            end
            ST_COMPUTE: begin
                weight_capture_s = cmd_load_s;
                issue_s          = proxy_in_valid;
            end
            default: begin
                weight_capture_s = 1'b0;
                issue_s          = 1'b0;
            end
        endcase
    end

    // Stationary weight and its loaded flag; weight survives leaving COMPUTE.
    always_ff @(posedge clk) begin
        if (rst) begin
            weight_r      <= {W{1'b0}};
            weight_loaded <= 1'b0;
        end else if (weight_capture_s) begin
            weight_r      <= rcm_weight;
            weight_loaded <= 1'b1;
        end else begin
            weight_r      <= weight_r;
            weight_loaded <= weight_loaded;
        end
    end

    // Sticky command error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_error <= 1'b0;
        end else if (error_set_s) begin
            cmd_error <= 1'b1;
        end else begin
            cmd_error <= cmd_error;
        end
    end

    // Sign-extend operands so the product is formed at full width.
    assign mul_a_s = {{W{proxy_left_in[W-1]}}, proxy_left_in};
    assign mul_b_s = {{W{weight_r[W-1]}}, weight_r};
    assign prod_s  = mul_a_s * mul_b_s;
    assign sum_s   = {{W{s1_top_r[W-1]}}, s1_top_r} + s1_prod_r;

    // Stage 1: product with the weight current at the issue edge, plus top.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_prod_r  <= {PW{1'b0}};
            s1_top_r   <= {W{1'b0}};
        end else if (issue_s) begin
            s1_valid_r <= 1'b1;
            s1_prod_r  <= prod_s;
            s1_top_r   <= proxy_top_in;
        end else begin
            s1_valid_r <= 1'b0;
            s1_prod_r  <= s1_prod_r;
            s1_top_r   <= s1_top_r;
        end
    end

    // Stage 2: full-width accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_sum_r   <= {PW{1'b0}};
        end else if (s1_valid_r) begin
            s2_valid_r <= 1'b1;
            s2_sum_r   <= sum_s;
        end else begin
            s2_valid_r <= 1'b0;
            s2_sum_r   <= s2_sum_r;
        end
    end

    // Output register: formatted result, held while no beat completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            proxy_result_valid <= 1'b0;
            proxy_result       <= {W{1'b0}};
        end else if (s2_valid_r) begin
            proxy_result_valid <= 1'b1;
            proxy_result       <= format_sum(s2_sum_r);
        end else begin
            proxy_result_valid <= 1'b0;
            proxy_result       <= proxy_result;
        end
    end

    assign proxy_state = state_r;

endmodule

// File: tb/tb_proxy_pe.sv
// -----------------------------------------------------------------------------
// tb_proxy_pe
//   Directed bench for proxy_pe. Two instances share stimulus: one wrapping
//   (SATURATE=0) and one clamping (SATURATE=1). Expected results are pushed to
//   a scoreboard queue when a beat is driven in COMPUTE and checked by a
//   negedge monitor against the edge at which they are due.
// -----------------------------------------------------------------------------
module tb_proxy_pe;

    localparam int W = 16;

    typedef struct {
        int          due;
        logic [W-1:0] exp_wrap;
        logic [W-1:0] exp_sat;
    } sb_entry_t;

    logic         clk;
    logic         rst;
    logic         load_proxy;
    logic         proxy_matmul;
    logic [2:0]   proxy_settings;
    logic [W-1:0] rcm_weight;
    logic [W-1:0] proxy_left_in;
    logic [W-1:0] proxy_top_in;
    logic         proxy_in_valid;

    logic [W-1:0] result_w;
    logic         result_valid_w;
    logic         weight_loaded_w;
    logic [1:0]   state_w;
    logic         cmd_error_w;
    logic [W-1:0] result_s;
    logic         result_valid_s;
    logic         weight_loaded_s;
    logic [1:0]   state_s;
    logic         cmd_error_s;

    int           vectors;
    int           miscompares;
    int           edge_cnt;
    bit           mon_en;
    sb_entry_t    sbq[$];
    logic [W-1:0] last_wrap;
    logic [W-1:0] last_sat;

    proxy_pe #(.WORD_SIZE(W), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .load_proxy(load_proxy), .proxy_matmul(proxy_matmul),
        .proxy_settings(proxy_settings), .rcm_weight(rcm_weight),
        .proxy_left_in(proxy_left_in), .proxy_top_in(proxy_top_in),
        .proxy_in_valid(proxy_in_valid), .proxy_result(result_w),
        .proxy_result_valid(result_valid_w), .weight_loaded(weight_loaded_w),
        .proxy_state(state_w), .cmd_error(cmd_error_w)
    );

    proxy_pe #(.WORD_SIZE(W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .load_proxy(load_proxy), .proxy_matmul(proxy_matmul),
        .proxy_settings(proxy_settings), .rcm_weight(rcm_weight),
        .proxy_left_in(proxy_left_in), .proxy_top_in(proxy_top_in),
        .proxy_in_valid(proxy_in_valid), .proxy_result(result_s),
        .proxy_result_valid(result_valid_s), .weight_loaded(weight_loaded_s),
        .proxy_state(state_s), .cmd_error(cmd_error_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference MAC: exact integer sum, then wrap or clamp to W bits.
    function automatic logic [W-1:0] model(input int left, input int top, input int w, input bit sat);
        longint s;
        s = longint'(top) + longint'(left) * longint'(w);
        if (sat && s > 64'sd32767) s = 64'sd32767;
        if (sat && s < -64'sd32768) s = -64'sd32768;
        return s[W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic ld, input logic mm, input logic [2:0] st, input int w);
        load_proxy     = ld;
        proxy_matmul   = mm;
        proxy_settings = st;
        rcm_weight     = W'(w);
    endtask

    // Drive one beat for the next edge and push its expected result (due two
    // edges after the issue edge).
    task automatic beat(input int left, input int top, input int w);
        sb_entry_t e;
        proxy_in_valid = 1'b1;
        proxy_left_in  = W'(left);
        proxy_top_in   = W'(top);
        e.due      = edge_cnt + 3;
        e.exp_wrap = model(left, top, w, 1'b0);
        e.exp_sat  = model(left, top, w, 1'b1);
        sbq.push_back(e);
    endtask

    task automatic no_beat();
        proxy_in_valid = 1'b0;
        proxy_left_in  = W'($urandom);
        proxy_top_in   = W'($urandom);
    endtask

    task automatic chk_ctl(input string tag, input logic [1:0] st, input logic wl, input logic ce);
        chk({tag, "_state"}, 32'(state_w), 32'(st));
        chk({tag, "_wloaded"}, 32'(weight_loaded_w), 32'(wl));
        chk({tag, "_cmderr"}, 32'(cmd_error_w), 32'(ce));
    endtask

    // Scoreboard monitor: a due entry must show valid and the right value;
    // otherwise valid must be low and the result must hold its last value.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() > 0 && sbq[0].due == edge_cnt) begin
                chk("valid_wrap", 32'(result_valid_w), 32'd1);
                chk("valid_sat", 32'(result_valid_s), 32'd1);
                chk("result_wrap", 32'(result_w), 32'(sbq[0].exp_wrap));
                chk("result_sat", 32'(result_s), 32'(sbq[0].exp_sat));
                last_wrap = sbq[0].exp_wrap;
                last_sat  = sbq[0].exp_sat;
                void'(sbq.pop_front());
            end else begin
                chk("idle_valid", 32'({result_valid_w, result_valid_s}), 32'd0);
                chk("hold_wrap", 32'(result_w), 32'(last_wrap));
                chk("hold_sat", 32'(result_s), 32'(last_sat));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        edge_cnt    = 0;
        mon_en      = 1'b0;
        last_wrap   = '0;
        last_sat    = '0;

        // Reset with random inputs.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_cmd(1'($urandom), 1'($urandom), 3'($urandom), int'($urandom));
            proxy_in_valid = 1'($urandom);
            proxy_left_in  = W'($urandom);
            proxy_top_in   = W'($urandom);
            tick();
        end
        chk_ctl("reset", 2'd0, 1'b0, 1'b0);
        chk("reset_result", 32'(result_w), 32'd0);
        chk("reset_valid", 32'({result_valid_w, result_valid_s}), 32'd0);
        chk("reset_sat_state", 32'(state_s), 32'd0);
        rst = 1'b0;
        set_cmd(1'b0, 1'b0, 3'b000, 0);
        no_beat();
        mon_en = 1'b1;
        tick();

        // Illegal commands: MATMUL in IDLE, then a load with bad settings.
        set_cmd(1'b0, 1'b1, 3'b110, 7);
        tick();
        chk_ctl("mm_idle", 2'd0, 1'b0, 1'b1);
        set_cmd(1'b1, 1'b0, 3'b011, 7);
        tick();
        chk_ctl("bad_load", 2'd0, 1'b0, 1'b1);
        set_cmd(1'b0, 1'b0, 3'b000, 0);
        tick();
        chk_ctl("sticky", 2'd0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_ctl("rst_clear", 2'd0, 1'b0, 1'b0);

        // Nominal: two loads (last wins), matmul with a nonzero weight bus.
        set_cmd(1'b1, 1'b0, 3'b001, 3);
        tick();
        chk_ctl("load1", 2'd1, 1'b1, 1'b0);
        set_cmd(1'b1, 1'b0, 3'b001, 5);
        tick();
        set_cmd(1'b0, 1'b1, 3'b110, 77);
        tick();
        chk_ctl("matmul", 2'd2, 1'b1, 1'b0);
        beat(2, 10, 5);
        tick();
        beat(-4, 1, 5);
        tick();
        beat(7, 0, 5);
        tick();
        no_beat();
        repeat (3) tick();

        // Bubbles: 1,0,1 with result held through the gap.
        beat(1, 1, 5);
        tick();
        no_beat();
        tick();
        beat(2, 2, 5);
        tick();
        no_beat();
        repeat (3) tick();

        // Drop matmul: back to IDLE with the weight retained.
        set_cmd(1'b0, 1'b0, 3'b000, 0);
        tick();
        chk_ctl("to_idle", 2'd0, 1'b1, 1'b0);

        // Overflow: w=300, left=+-300.
        set_cmd(1'b1, 1'b0, 3'b001, 300);
        tick();
        set_cmd(1'b0, 1'b1, 3'b110, 0);
        tick();
        beat(300, 0, 300);
        tick();
        beat(-300, 0, 300);
        tick();
        no_beat();
        repeat (3) tick();

        // Reload during COMPUTE: in-flight beat keeps the old weight.
        set_cmd(1'b1, 1'b0, 3'b001, 5);
        tick();
        set_cmd(1'b0, 1'b1, 3'b110, 0);
        tick();
        beat(1, 0, 5);
        tick();
        set_cmd(1'b1, 1'b0, 3'b001, 9);
        no_beat();
        tick();
        chk_ctl("reload", 2'd1, 1'b1, 1'b0);
        set_cmd(1'b0, 1'b0, 3'b000, 0);
        proxy_in_valid = 1'b1;
        repeat (3) tick();
        chk_ctl("loaded_hold", 2'd1, 1'b1, 1'b0);
        no_beat();
        set_cmd(1'b0, 1'b1, 3'b110, 0);
        tick();
        beat(1, 0, 9);
        tick();
        no_beat();
        repeat (4) tick();

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
